// File: rtl/model_dnc_pkg.sv
// -----------------------------------------------------------------------------
// model_dnc_pkg
// Shared types and constants for the DNC read-heads stage.
//   state_t      : controller FSM states
//   field_t      : which field of a read-head block is being handled
//   MODES        : read modes per head (backward, content, forward)
//   head_stride(): buffer slots reserved per head (W_MAX keys + beta + f + modes)
// -----------------------------------------------------------------------------
package model_dnc_pkg;

  localparam int MODES = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EMIT,
    DONE,
    FAIL
  } state_t;

  typedef enum logic [1:0] {
    FLD_K,
    FLD_BETA,
    FLD_F,
    FLD_PI
  } field_t;

  function automatic int head_stride(input int w_max, input int modes);
    return w_max + 2 + modes;
  endfunction

endpackage

// File: rtl/model_read_heads_buffer.sv
// -----------------------------------------------------------------------------
// model_read_heads_buffer
// Single-port synchronous register file holding the buffered interface words.
// One access per cycle: a write when we=1, otherwise a read when re=1. Read
// data is registered and holds its value on cycles without a read.
// Ports:
//   CLK   : clock
//   we    : write enable (wins over re)
//   re    : read enable
//   addr  : shared read/write address
//   wdata : write data
//   rdata : registered read data
// -----------------------------------------------------------------------------
module model_read_heads_buffer #(
  parameter int DATA_SIZE = 64,
  parameter int DEPTH     = 84,
  parameter int ADDR_W    = 7
) (
  input  logic                 CLK,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic [DATA_SIZE-1:0] rdata
);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  // NOTE: the storage array and read register have no reset; every slot is
  // written before it is read, and a reset port would prevent RAM mapping.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/model_read_heads_controller.sv
// -----------------------------------------------------------------------------
// model_read_heads_controller
// Buffers R read heads of interface words (per head: W keys, beta, f, MODES
// pi words) from a serial stream, then replays them as separate
// enable-qualified field streams, one word per cycle.
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   START               : begin a transaction (sampled in IDLE only)
//   READY / ERROR       : end-of-transaction pulse / invalid-size flag
//   SIZE_R_IN/SIZE_W_IN : head count R and key length W
//   XI_IN_ENABLE, XI_IN : input word stream; XI_IN_READY high while loading
//   K_OUT_I_ENABLE, K_OUT_K_ENABLE, K_OUT    : read keys
//   BETA_OUT_ENABLE, BETA_OUT                : read strengths
//   F_OUT_ENABLE, F_OUT                      : free gates
//   PI_OUT_I_ENABLE, PI_OUT_P_ENABLE, PI_OUT : read modes
// -----------------------------------------------------------------------------
module model_read_heads_controller
  import model_dnc_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int R_MAX        = 4,
  parameter int W_MAX        = 16,
  parameter int MODES        = model_dnc_pkg::MODES
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  output logic                 ERROR,
  input  logic [DATA_SIZE-1:0] SIZE_R_IN,
  input  logic [DATA_SIZE-1:0] SIZE_W_IN,
  input  logic                 XI_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] XI_IN,
  output logic                 XI_IN_READY,
  output logic                 K_OUT_I_ENABLE,
  output logic                 K_OUT_K_ENABLE,
  output logic [DATA_SIZE-1:0] K_OUT,
  output logic                 BETA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] BETA_OUT,
  output logic                 F_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] F_OUT,
  output logic                 PI_OUT_I_ENABLE,
  output logic                 PI_OUT_P_ENABLE,
  output logic [DATA_SIZE-1:0] PI_OUT
);

  localparam int STRIDE = head_stride(W_MAX, MODES);
  localparam int DEPTH  = R_MAX * STRIDE;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [CONTROL_SIZE-1:0] ONE = CONTROL_SIZE'(1);

  state_t                  state_q;
  field_t                  fld_q, fld_n;
  logic [CONTROL_SIZE-1:0] i_q, i_n, k_q, k_n, p_q, p_n;
  logic [CONTROL_SIZE-1:0] r_q, w_q;
  logic [CONTROL_SIZE-1:0] offset;
  logic                    last_word;
  logic                    size_bad;

  logic                    buf_we, buf_re;
  logic [ADDR_W-1:0]       buf_addr;
  logic [DATA_SIZE-1:0]    rd_data;

  // Last emitted value of each field; the data outputs show the fresh buffer
  // word while enabled and fall back to these otherwise.
  logic [DATA_SIZE-1:0]    k_hold, beta_hold, f_hold, pi_hold;

  assign size_bad = (SIZE_R_IN == '0) || (SIZE_R_IN > DATA_SIZE'(R_MAX)) ||
                    (SIZE_W_IN == '0) || (SIZE_W_IN > DATA_SIZE'(W_MAX));

  // Position walker shared by LOAD and EMIT: k -> beta -> f -> p, then next head.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fld_n     = fld_q;
    i_n       = i_q;
    k_n       = k_q;
    p_n       = p_q;
    last_word = 1'b0;
    unique case (fld_q)
      FLD_K: begin
        if (k_q == w_q - ONE) begin
          fld_n = FLD_BETA;
          k_n   = '0;
        end else begin
          k_n = k_q + ONE;
        end
      end
      FLD_BETA: fld_n = FLD_F;
      FLD_F: begin
        fld_n = FLD_PI;
        p_n   = '0;
      end
      FLD_PI: begin
        if (p_q == CONTROL_SIZE'(MODES - 1)) begin
          fld_n = FLD_K;
          p_n   = '0;
          if (i_q == r_q - ONE) begin
            last_word = 1'b1;
          end else begin
            i_n = i_q + ONE;
          end
        end else begin
          p_n = p_q + ONE;
        end
      end
    endcase
  end

  // Each head owns a fixed W_MAX-sized slot, so slots above runtime W stay unused.
  always_comb begin
    offset = '0;
    unique case (fld_q)
      FLD_K:    offset = k_q;
      FLD_BETA: offset = CONTROL_SIZE'(W_MAX);
      FLD_F:    offset = CONTROL_SIZE'(W_MAX + 1);
      FLD_PI:   offset = CONTROL_SIZE'(W_MAX + 2) + p_q;
    endcase
  end

  assign buf_addr = ADDR_W'(i_q * CONTROL_SIZE'(STRIDE) + offset);
  assign buf_we   = (state_q == LOAD) && XI_IN_ENABLE;
  assign buf_re   = (state_q == EMIT);

  model_read_heads_buffer #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_buffer (
    .CLK   (CLK),
    .we    (buf_we),
    .re    (buf_re),
    .addr  (buf_addr),
    .wdata (XI_IN),
    .rdata (rd_data)
  );

  assign K_OUT    = K_OUT_K_ENABLE  ? rd_data : k_hold;
  assign BETA_OUT = BETA_OUT_ENABLE ? rd_data : beta_hold;
  assign F_OUT    = F_OUT_ENABLE    ? rd_data : f_hold;
  assign PI_OUT   = PI_OUT_P_ENABLE ? rd_data : pi_hold;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= IDLE;
      fld_q           <= FLD_K;
      i_q             <= '0;
      k_q             <= '0;
      p_q             <= '0;
      r_q             <= '0;
      w_q             <= '0;
      READY           <= 1'b0;
      ERROR           <= 1'b0;
      XI_IN_READY     <= 1'b0;
      K_OUT_I_ENABLE  <= 1'b0;
      K_OUT_K_ENABLE  <= 1'b0;
      BETA_OUT_ENABLE <= 1'b0;
      F_OUT_ENABLE    <= 1'b0;
      PI_OUT_I_ENABLE <= 1'b0;
      PI_OUT_P_ENABLE <= 1'b0;
      k_hold          <= '0;
      beta_hold       <= '0;
      f_hold          <= '0;
      pi_hold         <= '0;
    end else begin
      READY           <= 1'b0;
      ERROR           <= 1'b0;
      K_OUT_I_ENABLE  <= 1'b0;
      K_OUT_K_ENABLE  <= 1'b0;
      BETA_OUT_ENABLE <= 1'b0;
      F_OUT_ENABLE    <= 1'b0;
      PI_OUT_I_ENABLE <= 1'b0;
      PI_OUT_P_ENABLE <= 1'b0;

      if (K_OUT_K_ENABLE)  k_hold    <= rd_data;
      if (BETA_OUT_ENABLE) beta_hold <= rd_data;
      if (F_OUT_ENABLE)    f_hold    <= rd_data;
      if (PI_OUT_P_ENABLE) pi_hold   <= rd_data;

      unique case (state_q)
        IDLE: begin
          if (START) begin
            r_q   <= CONTROL_SIZE'(SIZE_R_IN);
            w_q   <= CONTROL_SIZE'(SIZE_W_IN);
            fld_q <= FLD_K;
            i_q   <= '0;
            k_q   <= '0;
            p_q   <= '0;
            if (size_bad) begin
              state_q <= FAIL;
            end else begin
              state_q     <= LOAD;
              XI_IN_READY <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (XI_IN_ENABLE) begin
            fld_q <= fld_n;
            k_q   <= k_n;
            p_q   <= p_n;
            i_q   <= i_n;
            if (last_word) begin
              state_q     <= EMIT;
              XI_IN_READY <= 1'b0;
              i_q         <= '0;
            end
          end
        end

        EMIT: begin
          // Enables line up with the buffer word read at this same edge.
          K_OUT_I_ENABLE  <= (fld_q == FLD_K) && (k_q == '0);
          K_OUT_K_ENABLE  <= (fld_q == FLD_K);
          BETA_OUT_ENABLE <= (fld_q == FLD_BETA);
          F_OUT_ENABLE    <= (fld_q == FLD_F);
          PI_OUT_I_ENABLE <= (fld_q == FLD_PI) && (p_q == '0);
          PI_OUT_P_ENABLE <= (fld_q == FLD_PI);
          fld_q <= fld_n;
          k_q   <= k_n;
          p_q   <= p_n;
          i_q   <= i_n;
          if (last_word) begin
            state_q <= DONE;
            i_q     <= '0;
          end
        end

        DONE: begin
          READY   <= 1'b1;
          state_q <= IDLE;
        end

        FAIL: begin
          READY   <= 1'b1;
          ERROR   <= 1'b1;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_model_read_heads_controller.sv
// -----------------------------------------------------------------------------
// tb_model_read_heads_controller
// Scoreboard bench: stimulus pushes the expected emitted words (derived from
// the block layout W keys, beta, f, 3 pi words per head) and a READY/ERROR
// entry into exp_q; an independent monitor pops and compares whenever the DUT
// presents an output.
// -----------------------------------------------------------------------------
module tb_model_read_heads_controller;

  localparam int DS = 64;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          READY, ERROR;
  logic [DS-1:0] SIZE_R_IN = '0, SIZE_W_IN = '0;
  logic          XI_IN_ENABLE = 1'b0;
  logic [DS-1:0] XI_IN = '0;
  logic          XI_IN_READY;
  logic          K_OUT_I_ENABLE, K_OUT_K_ENABLE;
  logic [DS-1:0] K_OUT;
  logic          BETA_OUT_ENABLE;
  logic [DS-1:0] BETA_OUT;
  logic          F_OUT_ENABLE;
  logic [DS-1:0] F_OUT;
  logic          PI_OUT_I_ENABLE, PI_OUT_P_ENABLE;
  logic [DS-1:0] PI_OUT;

  always #5 CLK = ~CLK;

  model_read_heads_controller dut (
    .CLK             (CLK),
    .RST             (RST),
    .START           (START),
    .READY           (READY),
    .ERROR           (ERROR),
    .SIZE_R_IN       (SIZE_R_IN),
    .SIZE_W_IN       (SIZE_W_IN),
    .XI_IN_ENABLE    (XI_IN_ENABLE),
    .XI_IN           (XI_IN),
    .XI_IN_READY     (XI_IN_READY),
    .K_OUT_I_ENABLE  (K_OUT_I_ENABLE),
    .K_OUT_K_ENABLE  (K_OUT_K_ENABLE),
    .K_OUT           (K_OUT),
    .BETA_OUT_ENABLE (BETA_OUT_ENABLE),
    .BETA_OUT        (BETA_OUT),
    .F_OUT_ENABLE    (F_OUT_ENABLE),
    .F_OUT           (F_OUT),
    .PI_OUT_I_ENABLE (PI_OUT_I_ENABLE),
    .PI_OUT_P_ENABLE (PI_OUT_P_ENABLE),
    .PI_OUT          (PI_OUT)
  );

  typedef enum int {EV_K = 0, EV_BETA = 1, EV_F = 2, EV_PI = 3, EV_READY = 4} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    logic [DS-1:0] data;
    bit            first;
    bit            err;
  } ev_t;

  ev_t           exp_q[$];
  logic [DS-1:0] stim_q[$];
  int            total = 0;
  int            bad = 0;

  task automatic check(input string name, input logic [DS-1:0] act, input logic [DS-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: emit order equals input order; the field of word n follows
  // from its position inside its (W+5)-word head block.
  task automatic push_expected(input int r, input int w);
    int blk;
    ev_t e;
    blk = w + 2 + 3;
    for (int n = 0; n < r * blk; n++) begin
      int j;
      j       = n % blk;
      e.data  = stim_q[n];
      e.err   = 1'b0;
      e.first = 1'b0;
      if (j < w) begin
        e.kind  = EV_K;
        e.first = (j == 0);
      end else if (j == w) begin
        e.kind = EV_BETA;
      end else if (j == w + 1) begin
        e.kind = EV_F;
      end else begin
        e.kind  = EV_PI;
        e.first = (j == w + 2);
      end
      exp_q.push_back(e);
    end
    e.kind  = EV_READY;
    e.data  = '0;
    e.first = 1'b0;
    e.err   = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {READY, ERROR, XI_IN_READY, K_OUT_I_ENABLE, K_OUT_K_ENABLE,
                           BETA_OUT_ENABLE, F_OUT_ENABLE, PI_OUT_I_ENABLE, PI_OUT_P_ENABLE}, '0);
    check({tag, "_k"}, K_OUT, '0);
    check({tag, "_beta"}, BETA_OUT, '0);
    check({tag, "_f"}, F_OUT, '0);
    check({tag, "_pi"}, PI_OUT, '0);
  endtask

  // gap: 0 continuous, 1 enable low every third cycle, 2 random gaps.
  // poke: pulse START and toggle XI_IN_ENABLE while emitting.
  task automatic run_txn(input int r, input int w, input int gap, input bit poke);
    int n;
    int idx;
    int c;
    int guard;
    bit en;
    n   = stim_q.size();
    idx = 0;
    c   = 0;
    @(posedge CLK); #1;
    START     = 1'b1;
    SIZE_R_IN = DS'(r);
    SIZE_W_IN = DS'(w);
    @(posedge CLK); #1;
    START     = 1'b0;
    SIZE_R_IN = {$urandom, $urandom};
    SIZE_W_IN = {$urandom, $urandom};
    check("load_ready", XI_IN_READY, 1);
    while (idx < n) begin
      case (gap)
        0:       en = 1'b1;
        1:       en = (c % 3) != 2;
        default: en = $urandom_range(0, 3) != 0;
      endcase
      if (en && idx == n - 1) push_expected(r, w);
      XI_IN        = en ? stim_q[idx] : {$urandom, $urandom};
      XI_IN_ENABLE = en;
      if (en) idx++;
      c++;
      @(posedge CLK); #1;
    end
    XI_IN_ENABLE = 1'b0;
    check("load_exit", XI_IN_READY, 0);
    @(negedge CLK);
    check("latency_gap", K_OUT_K_ENABLE, 0);
    @(negedge CLK);
    check("latency_first", {K_OUT_I_ENABLE, K_OUT_K_ENABLE}, 2'b11);
    if (poke) begin
      @(posedge CLK); #1;
      START        = 1'b1;
      SIZE_R_IN    = 1;
      SIZE_W_IN    = 1;
      XI_IN_ENABLE = 1'b1;
      XI_IN        = {$urandom, $urandom};
      @(posedge CLK); #1;
      START        = 1'b0;
      XI_IN_ENABLE = 1'b0;
      @(posedge CLK); #1;
      XI_IN_ENABLE = 1'b1;
      @(posedge CLK); #1;
      XI_IN_ENABLE = 1'b0;
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge CLK);
      guard++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) begin
      @(negedge CLK);
      check("no_restart", XI_IN_READY, 0);
    end
  endtask

  task automatic run_bad(input logic [DS-1:0] r, input logic [DS-1:0] w);
    ev_t e;
    e.kind  = EV_READY;
    e.data  = '0;
    e.first = 1'b0;
    e.err   = 1'b1;
    @(posedge CLK); #1;
    START     = 1'b1;
    SIZE_R_IN = r;
    SIZE_W_IN = w;
    exp_q.push_back(e);
    @(posedge CLK); #1;
    START = 1'b0;
    @(negedge CLK);
    check("bad_c1_ready", {READY, XI_IN_READY}, 2'b00);
    @(negedge CLK);
    check("bad_c2_ready_error", {READY, ERROR}, 2'b11);
    check("bad_c2_xi_ready", XI_IN_READY, 0);
    @(negedge CLK);
    check("bad_c3", {READY, ERROR, XI_IN_READY}, 3'b000);
    exp_q.delete();
  endtask

  task automatic fill_random(input int cnt);
    stim_q.delete();
    for (int q = 0; q < cnt; q++) stim_q.push_back({$urandom, $urandom});
  endtask

  // Monitor: pops one expected entry per presented output.
  initial begin : monitor
    ev_t           e;
    logic [7:0]    pv;
    int            n_en;
    int            fk;
    bit            prev_emit;
    logic [DS-1:0] last_out [4];
    logic [DS-1:0] act [4];
    prev_emit = 1'b0;
    for (int f = 0; f < 4; f++) last_out[f] = '0;
    forever begin
      @(negedge CLK);
      act[0] = K_OUT;
      act[1] = BETA_OUT;
      act[2] = F_OUT;
      act[3] = PI_OUT;
      pv = {READY, ERROR, K_OUT_I_ENABLE, K_OUT_K_ENABLE, BETA_OUT_ENABLE,
            F_OUT_ENABLE, PI_OUT_I_ENABLE, PI_OUT_P_ENABLE};
      n_en = int'(K_OUT_K_ENABLE) + int'(BETA_OUT_ENABLE) + int'(F_OUT_ENABLE) +
             int'(PI_OUT_P_ENABLE);
      if (RST) begin
        for (int f = 0; f < 4; f++) last_out[f] = '0;
        prev_emit = 1'b0;
      end else if (pv != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", pv, '0);
          prev_emit = 1'b0;
        end else begin
          e = exp_q.pop_front();
          if (e.kind == EV_READY) begin
            check("ready", READY, 1);
            check("error_flag", ERROR, e.err);
            check("ready_no_data", pv[5:0], '0);
          end else begin
            fk = int'(e.kind);
            check("one_enable", n_en, 1);
            check("field_enable", {K_OUT_K_ENABLE, BETA_OUT_ENABLE, F_OUT_ENABLE, PI_OUT_P_ENABLE},
                  4'b1000 >> fk);
            check("field_data", act[fk], e.data);
            check("k_first", K_OUT_I_ENABLE, (e.kind == EV_K) && e.first);
            check("pi_first", PI_OUT_I_ENABLE, (e.kind == EV_PI) && e.first);
            check("no_ready_in_emit", {READY, ERROR}, 2'b00);
            for (int f = 0; f < 4; f++) begin
              if (f != fk) check("hold_value", act[f], last_out[f]);
            end
            last_out[fk] = e.data;
          end
          prev_emit = (e.kind != EV_READY);
        end
      end else begin
        if (prev_emit && exp_q.size() != 0) check("stream_gap", pv, 8'h01);
        prev_emit = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int r;
    int w;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check_all_zero("reset");

    // R=1, W=2, words 1..7 back to back.
    stim_q.delete();
    for (int v = 1; v <= 7; v++) stim_q.push_back(DS'(v));
    run_txn(1, 2, 0, 1'b0);

    // Full size R=4, W=16, words 0..83 with every third enable dropped.
    stim_q.delete();
    for (int v = 0; v < 84; v++) stim_q.push_back(DS'(v));
    run_txn(4, 16, 1, 1'b0);

    // Invalid sizes, including values that only differ above bit 31.
    run_bad(64'd5, 64'd2);
    run_bad(64'd1, 64'd0);
    run_bad(64'd0, 64'd4);
    run_bad(64'd2, 64'd17);
    run_bad(64'h0000_0001_0000_0001, 64'd4);
    run_bad(64'd2, 64'h8000_0000_0000_0003);

    // Reset in the middle of loading: no READY, everything cleared.
    @(posedge CLK); #1;
    START     = 1'b1;
    SIZE_R_IN = 2;
    SIZE_W_IN = 4;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int q = 0; q < 5; q++) begin
      XI_IN        = {$urandom, $urandom};
      XI_IN_ENABLE = 1'b1;
      @(posedge CLK); #1;
    end
    XI_IN_ENABLE = 1'b0;
    RST          = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check_all_zero("abort");
    repeat (4) begin
      @(negedge CLK);
      check("abort_no_ready", {READY, XI_IN_READY}, 2'b00);
    end

    // Smallest key after the abort.
    stim_q.delete();
    stim_q.push_back(64'd10);
    stim_q.push_back(64'd20);
    stim_q.push_back(64'd30);
    stim_q.push_back(64'd40);
    stim_q.push_back(64'd41);
    stim_q.push_back(64'd42);
    run_txn(1, 1, 0, 1'b0);

    // START and XI_IN_ENABLE activity during EMIT must be ignored.
    fill_random(2 * 8);
    run_txn(2, 3, 2, 1'b1);

    // Randomized valid and invalid transactions.
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 3))
          0:       run_bad(64'd0, DS'($urandom_range(1, 16)));
          1:       run_bad(DS'($urandom_range(5, 1000)), DS'($urandom_range(1, 16)));
          2:       run_bad(DS'($urandom_range(1, 4)), 64'd0);
          default: run_bad(DS'($urandom_range(1, 4)), DS'($urandom_range(17, 100)));
        endcase
      end else begin
        r = $urandom_range(1, 4);
        w = $urandom_range(1, 16);
        fill_random(r * (w + 5));
        run_txn(r, w, 2, ($urandom_range(0, 3) == 0));
      end
    end

    repeat (4) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
